// File: rtl/prefetch_ctrl.sv
// prefetch_ctrl
//   Sequencing controller for the rv32i instruction prefetch FIFO. Issues
//   word-aligned fetch requests, tracks FIFO occupancy plus in-flight
//   requests so every returned word has a guaranteed slot, tags written
//   words with {err, pc}, and on a jump flushes the FIFO, redirects, and
//   drops responses that were already in flight.
//
//   Optional feature macro: PREFETCH_CTRL_ERR_HALT_EN
//     defined   : an error response written to the FIFO halts fetching until jump_i.
//     undefined : errors are only tagged; fetching continues sequentially.
//
// Ports
//   clk_i        clock
//   clk_en_i     clock enable; qualifies all state updates and handshakes
//   resetb_i     asynchronous active-low reset
//   jump_i       redirect request
//   jump_addr_i  redirect target (bits [1:0] ignored)
//   ireqvalid_o  fetch request valid
//   ireqready_i  bus accepts the request
//   ireqaddr_o   fetch address (word aligned)
//   irspvalid_i  response valid (in request order)
//   irsperr_i    response bus error
//   fifo_flush_o FIFO flush
//   fifo_wr_o    FIFO write
//   fifo_tag_o   {err, pc} stored with the instruction word
//   fifo_rd_i    FIFO read from the decoder

module prefetch_ctrl #(
    parameter int unsigned C_FIFO_DEPTH_X = 2,
    parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        clk_en_i,
    input  logic        resetb_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        ireqvalid_o,
    input  logic        ireqready_i,
    output logic [31:0] ireqaddr_o,
    input  logic        irspvalid_i,
    input  logic        irsperr_i,
    output logic        fifo_flush_o,
    output logic        fifo_wr_o,
    output logic [32:0] fifo_tag_o,
    input  logic        fifo_rd_i
);

    localparam int unsigned CNT_W = C_FIFO_DEPTH_X + 1;
    localparam int unsigned SUM_W = C_FIFO_DEPTH_X + 2;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << C_FIFO_DEPTH_X;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic [CNT_W-1:0]  outst_q;
    logic [CNT_W-1:0]  discard_q;
    logic [31:0]       req_addr_q;
    logic [31:0]       rsp_pc_q;

    logic              jump;
    logic              rsp;
    logic              rd;
    logic              credit;
    logic              req_valid;
    logic              hs;
    logic              drop_rsp;
    logic              wr;
    logic              err_halt;
    logic [31:0]       jump_target;

    // Event decode, all qualified by the clock enable
    assign jump        = jump_i & clk_en_i;
    assign rsp         = irspvalid_i & clk_en_i;
    assign rd          = fifo_rd_i & clk_en_i;
    assign jump_target = jump_addr_i & ~32'h3;

    // Credit: FIFO words plus in-flight requests must leave a slot free
    assign credit    = (SUM_W'(fifo_cnt_q) + SUM_W'(outst_q)) < SUM_W'(DEPTH);
    assign req_valid = clk_en_i & (state_q == S_RUN) & ~jump_i & credit;
    assign hs        = req_valid & ireqready_i;

    // Responses owed to a pre-jump stream are dropped; a jump drops the
    // response arriving in the same cycle too
    assign drop_rsp = rsp & (discard_q != '0);
    assign wr       = rsp & ~jump & (discard_q == '0);

`ifdef PREFETCH_CTRL_ERR_HALT_EN
    assign err_halt = wr & irsperr_i;
`else
    assign err_halt = 1'b0;
`endif

    // Outputs
    assign ireqvalid_o  = req_valid;
    assign ireqaddr_o   = req_addr_q;
    assign fifo_flush_o = jump;
    assign fifo_wr_o    = wr;
    assign fifo_tag_o   = {irsperr_i & wr, rsp_pc_q};

    // State machine, counters and address registers
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q    <= S_IDLE;
            fifo_cnt_q <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            req_addr_q <= C_RESET_VECTOR;
            rsp_pc_q   <= C_RESET_VECTOR;
        end else if (clk_en_i) begin
            if (jump_i) begin
                state_q <= S_RUN;
            end else begin
                case (state_q)
                    S_IDLE:  state_q <= S_RUN;
                    S_RUN:   if (err_halt) state_q <= S_HALT;
                    S_HALT:  state_q <= S_HALT;
                    default: state_q <= S_IDLE;
                endcase
            end

            if (jump_i) begin
                fifo_cnt_q <= '0;
            end else begin
                case ({wr, rd})
                    2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                    2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                    default: fifo_cnt_q <= fifo_cnt_q;
                endcase
            end

            case ({hs, rsp})
                2'b10:   outst_q <= outst_q + CNT_W'(1);
                2'b01:   outst_q <= outst_q - CNT_W'(1);
                default: outst_q <= outst_q;
            endcase

            // Everything still in flight after this cycle belongs to the old stream
            if (jump_i) begin
                discard_q <= outst_q - CNT_W'(irspvalid_i);
            end else if (drop_rsp) begin
                discard_q <= discard_q - CNT_W'(1);
            end

            if (jump_i) begin
                req_addr_q <= jump_target;
            end else if (hs) begin
                req_addr_q <= req_addr_q + 32'd4;
            end

            if (jump_i) begin
                rsp_pc_q <= jump_target;
            end else if (wr) begin
                rsp_pc_q <= rsp_pc_q + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Bench for prefetch_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.

module tb_prefetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0100;
    localparam int DEPTH = 4;

    logic        clk;
    logic        clk_en;
    logic        resetb;
    logic        jump;
    logic [31:0] jump_addr;
    logic        ireqvalid;
    logic        ireqready;
    logic [31:0] ireqaddr;
    logic        irspvalid;
    logic        irsperr;
    logic        fifo_flush;
    logic        fifo_wr;
    logic [32:0] fifo_tag;
    logic        fifo_rd;

    prefetch_ctrl #(
        .C_FIFO_DEPTH_X(2),
        .C_RESET_VECTOR(RV)
    ) dut (
        .clk_i       (clk),
        .clk_en_i    (clk_en),
        .resetb_i    (resetb),
        .jump_i      (jump),
        .jump_addr_i (jump_addr),
        .ireqvalid_o (ireqvalid),
        .ireqready_i (ireqready),
        .ireqaddr_o  (ireqaddr),
        .irspvalid_i (irspvalid),
        .irsperr_i   (irsperr),
        .fifo_flush_o(fifo_flush),
        .fifo_wr_o   (fifo_wr),
        .fifo_tag_o  (fifo_tag),
        .fifo_rd_i   (fifo_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queue of in-flight requests, each remembering its PC and
    // whether a later jump orphaned it; FIFO occupancy as a plain count.
    typedef struct packed {
        logic [31:0] pc;
        logic        drop;
    } ent_t;

    ent_t        q[$];
    int          m_fifo;
    logic [31:0] m_addr;
    bit          m_started;
    bit          m_halted;

    // Outputs sampled in the latest step
    logic        s_valid;
    logic [31:0] s_addr;
    logic        s_wr;
    logic        s_flush;
    logic [32:0] s_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fifo    = 0;
        m_addr    = RV;
        m_started = 1'b0;
        m_halted  = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare against the model at the
    // falling edge, advance the model, then move past the rising edge.
    task automatic step(input bit en, input bit jmp, input logic [31:0] ja,
                        input bit rdy, input bit rv, input bit re, input bit rd);
        bit   e_valid;
        bit   e_wr;
        bit   e_flush;
        bit   j;
        bit   r;
        bit   hs;
        ent_t front;

        clk_en    = en;
        jump      = jmp;
        jump_addr = ja;
        ireqready = rdy;
        irspvalid = rv;
        irsperr   = re;
        fifo_rd   = rd;
        @(negedge clk);

        s_valid = ireqvalid;
        s_addr  = ireqaddr;
        s_wr    = fifo_wr;
        s_flush = fifo_flush;
        s_tag   = fifo_tag;

        j       = en && jmp;
        r       = en && rv;
        e_valid = en && m_started && !m_halted && !jmp && ((m_fifo + q.size()) < DEPTH);
        e_flush = j;
        e_wr    = 1'b0;
        front   = '0;
        if (r) begin
            front = q.pop_front();
            e_wr  = !j && !front.drop;
        end

        check("valid", 64'(s_valid), 64'(e_valid));
        check("addr",  64'(s_addr),  64'(m_addr));
        check("flush", 64'(s_flush), 64'(e_flush));
        check("wr",    64'(s_wr),    64'(e_wr));
        if (e_wr) check("tag", 64'(s_tag), 64'({re, front.pc}));

        hs = e_valid && rdy;
        if (hs) q.push_back('{pc: m_addr, drop: 1'b0});
        if (j) begin
            foreach (q[i]) q[i].drop = 1'b1;
            m_fifo   = 0;
            m_addr   = ja & ~32'h3;
            m_halted = 1'b0;
        end else begin
            if (e_wr) m_fifo++;
            if (en && rd) m_fifo--;
            if (hs) m_addr = m_addr + 32'd4;
`ifdef PREFETCH_CTRL_ERR_HALT_EN
            if (e_wr && re && m_started) m_halted = 1'b1;
`endif
        end
        if (en) m_started = 1'b1;

        @(posedge clk);
        #1;
    endtask

    initial begin
        resetb    = 1'b0;
        clk_en    = 1'b0;
        jump      = 1'b0;
        jump_addr = '0;
        ireqready = 1'b0;
        irspvalid = 1'b0;
        irsperr   = 1'b0;
        fifo_rd   = 1'b0;
        model_reset();

        // Reset values
        @(negedge clk);
        check("rst_valid", 64'(ireqvalid),  64'(0));
        check("rst_addr",  64'(ireqaddr),   64'(RV));
        check("rst_tag",   64'(fifo_tag),   64'(33'h0_0000_0100));
        check("rst_wr",    64'(fifo_wr),    64'(0));
        check("rst_flush", 64'(fifo_flush), 64'(0));
        @(posedge clk);
        #1 resetb = 1'b1;

        // Fill credit with no responses: 0x100..0x10C then stall
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 1, 0, 0, 0);
            if (i == 0) check("first_idle", 64'(s_valid), 64'(0));
            if (i == 1) check("first_req", 64'({s_valid, s_addr}), 64'({1'b1, 32'h100}));
            if (i == 4) check("fourth_req", 64'({s_valid, s_addr}), 64'({1'b1, 32'h10C}));
            if (i == 5) check("credit_stall", 64'(s_valid), 64'(0));
        end

        // Four responses written in order
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 1, 0, 0);
            if (i == 0) check("wr_tag0", 64'({s_wr, s_tag}), 64'({1'b1, 33'h0_0000_0100}));
            if (i == 3) check("wr_tag3", 64'({s_wr, s_tag}), 64'({1'b1, 33'h0_0000_010C}));
        end
        step(1, 0, 0, 1, 0, 0, 0);
        check("full_stall", 64'(s_valid), 64'(0));
        step(1, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0, 0);
        check("one_req", 64'({s_valid, s_addr}), 64'({1'b1, 32'h110}));
        step(1, 0, 0, 1, 0, 0, 0);
        check("one_req_only", 64'(s_valid), 64'(0));

        // Reach FIFO=1, two outstanding, then jump to 0x2003
        step(1, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0, 1);
        step(1, 1, 32'h2003, 1, 0, 0, 0);
        check("jump_flush", 64'({s_flush, s_wr, s_valid}), 64'(3'b100));
        step(1, 0, 0, 1, 1, 0, 0);
        check("jump_req", 64'({s_valid, s_addr, s_wr}), 64'({1'b1, 32'h2000, 1'b0}));
        step(1, 0, 0, 0, 1, 0, 0);
        check("drop2", 64'(s_wr), 64'(0));
        step(1, 0, 0, 0, 1, 0, 0);
        check("jump_wr", 64'({s_wr, s_tag}), 64'({1'b1, 33'h0_0000_2000}));

        // Jump coincident with the only outstanding response
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 32'h3000, 0, 1, 0, 0);
        check("jrsp_drop", 64'({s_flush, s_wr}), 64'(2'b10));
        step(1, 0, 0, 1, 0, 0, 0);
        check("jrsp_req", 64'({s_valid, s_addr}), 64'({1'b1, 32'h3000}));
        step(1, 0, 0, 0, 1, 0, 0);
        check("jrsp_wr", 64'({s_wr, s_tag}), 64'({1'b1, 33'h0_0000_3000}));

        // Error response at 0x40
        step(1, 1, 32'h40, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 0);
        check("err_tag", 64'({s_wr, s_tag}), 64'({1'b1, 33'h1_0000_0040}));
        step(1, 0, 0, 1, 0, 0, 0);
`ifdef PREFETCH_CTRL_ERR_HALT_EN
        check("err_halt", 64'(s_valid), 64'(0));
`else
        check("err_cont", 64'({s_valid, s_addr}), 64'({1'b1, 32'h48}));
`endif
        step(1, 0, 0, 0, 1, 0, 0);
        check("err_drain", 64'({s_wr, s_tag}), 64'({1'b1, 33'h0_0000_0044}));

        // Address wrap and clock-enable freeze
        step(1, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        check("wrap_pre", 64'({s_valid, s_addr}), 64'({1'b1, 32'hFFFF_FFFC}));
        step(1, 0, 0, 0, 0, 0, 0);
        check("wrap_post", 64'({s_valid, s_addr}), 64'({1'b1, 32'h0}));
        step(0, 0, 0, 1, 0, 0, 0);
        check("en_off", 64'({s_valid, s_addr}), 64'({1'b0, 32'h0}));
        step(0, 1, 32'h5000, 1, 0, 0, 0);
        check("en_off_jump", 64'({s_flush, s_valid, s_addr}), 64'({2'b00, 32'h0}));
        step(1, 0, 0, 1, 0, 0, 0);
        check("en_on", 64'({s_valid, s_addr}), 64'({1'b1, 32'h0}));

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit          en;
            bit          jmp;
            bit          rv;
            bit          rd;
            logic [31:0] ja;
            en  = ($urandom % 8) != 0;
            jmp = ($urandom % 24) == 0;
            ja  = $urandom;
            rv  = en && (q.size() > 0) && (($urandom % 3) != 0);
            rd  = (m_fifo > 0) && (($urandom % 2) == 1);
            step(en, jmp, ja, ($urandom % 4) != 0, rv, ($urandom % 10) == 0, rd);
        end

        // Asynchronous reset mid-operation
        clk_en    = 1'b1;
        jump      = 1'b0;
        irspvalid = 1'b0;
        fifo_rd   = 1'b0;
        ireqready = 1'b1;
        resetb    = 1'b0;
        #1;
        check("mid_rst_valid", 64'(ireqvalid), 64'(0));
        check("mid_rst_addr",  64'(ireqaddr),  64'(RV));
        model_reset();
        @(posedge clk);
        #1 resetb = 1'b1;
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
